// File: rtl/smvm_batch_scheduler.sv
// Front-end scheduler for the sparse matrix-vector multiply datapath: parses header, vector and
// nonzero entries, packs entries into K-lane groups and tracks row completions. Optional macro: SMVM_COL_CHECK_EN.
module smvm_batch_scheduler #(
    parameter int K    = 4,
    parameter int COLW = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic [COLW-1:0]      in_col,
    input  logic                 in_ipv,
    input  logic                 in_last,
    output logic                 vec_we,
    output logic [COLW-1:0]      vec_waddr,
    output logic [7:0]           vec_wdata,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [8*K-1:0]       iss_val,
    output logic [COLW*K-1:0]    iss_col,
    output logic [K-1:0]         iss_ipv,
    output logic [K-1:0]         iss_mask,
    output logic                 iss_last,
    input  logic                 row_done,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int FW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {IDLE, HDR_COL, VEC, ENT, WAIT_DONE} state_t;

    state_t              state, state_nx;
    logic [7:0]          rows, cols, vec_cnt, rows_seen;
    logic [FW-1:0]       fill;
    logic [8*K-1:0]      stg_val, grp_val;
    logic [COLW*K-1:0]   stg_col, grp_col;
    logic [K-1:0]        stg_ipv, grp_ipv, stg_mask, grp_mask;
    logic [7:0]          beat_val;
    logic                accept, grp_close, finish, col_bad;

    assign accept    = in_valid && in_ready;
    assign grp_close = in_last || (fill == FW'(K-1));
    assign finish    = (rows_seen == rows) || (rows == 8'd0);

`ifdef SMVM_COL_CHECK_EN
    // cols == 128 covers the whole vector buffer, so no index can be out of range.
    assign col_bad  = (cols != 8'd128) && (8'(in_col) >= cols);
    assign beat_val = col_bad ? 8'd0 : in_data;
`else
    assign col_bad  = 1'b0;
    assign beat_val = in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        // NOTE: default every comb output first so no path leaves it unassigned (no latch).
        state_nx = state;
        unique case (state)
            IDLE:      if (accept) state_nx = HDR_COL;
            HDR_COL:   if (accept) state_nx = VEC;
            VEC:       if (accept && vec_cnt == cols - 8'd1) state_nx = ENT;
            ENT:       if (iss_valid && iss_ready && iss_last) state_nx = WAIT_DONE;
            WAIT_DONE: if (finish) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        vec_we    = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        vec_waddr = vec_cnt[COLW-1:0];
        vec_wdata = in_data;
        unique case (state)
            IDLE, HDR_COL: in_ready = 1'b1;
            VEC: begin
                in_ready = 1'b1;
                vec_we   = in_valid;
            end
            // Once the final group is held, further beats belong to the next job and must wait.
            ENT:       in_ready = (!iss_valid || iss_ready) && !iss_last;
            WAIT_DONE: done = finish;
            default:   in_ready = 1'b0;
        endcase
    end

    // Staging group with the current beat merged into lane[fill]; lane 0 sits in the MSBs.
    always_comb begin
        int lane;
        lane     = K - 1 - int'(fill);
        grp_val  = stg_val;
        grp_col  = stg_col;
        grp_ipv  = stg_ipv;
        grp_mask = stg_mask;
        grp_val[8*lane +: 8]       = beat_val;
        grp_col[COLW*lane +: COLW] = in_col;
        grp_ipv[lane]              = in_ipv;
        grp_mask[lane]             = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows      <= '0;
            cols      <= '0;
            vec_cnt   <= '0;
            rows_seen <= '0;
            fill      <= '0;
            stg_val   <= '0;
            stg_col   <= '0;
            stg_ipv   <= '0;
            stg_mask  <= '0;
            iss_valid <= 1'b0;
            iss_last  <= 1'b0;
            iss_val   <= '0;
            iss_col   <= '0;
            iss_ipv   <= '0;
            iss_mask  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            if (state == IDLE && accept) begin
                rows      <= in_data;
                rows_seen <= '0;
            end
            if (state == HDR_COL && accept) begin
                cols    <= (in_data == 8'd0) ? 8'd128 : in_data;
                vec_cnt <= '0;
            end
            if (state == VEC && accept) vec_cnt <= vec_cnt + 8'd1;
            if (state == WAIT_DONE && row_done && rows_seen != rows) rows_seen <= rows_seen + 8'd1;
            if (iss_valid && iss_ready) begin
                iss_valid <= 1'b0;
                iss_last  <= 1'b0;
            end
            if (state == ENT && accept) begin
                if (grp_close) begin
                    iss_val   <= grp_val;
                    iss_col   <= grp_col;
                    iss_ipv   <= grp_ipv;
                    iss_mask  <= grp_mask;
                    iss_valid <= 1'b1;
                    iss_last  <= in_last;
                    stg_val   <= '0;
                    stg_col   <= '0;
                    stg_ipv   <= '0;
                    stg_mask  <= '0;
                    fill      <= '0;
                end else begin
                    stg_val  <= grp_val;
                    stg_col  <= grp_col;
                    stg_ipv  <= grp_ipv;
                    stg_mask <= grp_mask;
                    fill     <= fill + FW'(1);
                end
            end
        end
    end

`ifdef SMVM_COL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)                                      err <= 1'b0;
        else if (state == ENT && accept && col_bad)   err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
